// File: rtl/regfile_dump_reader_pkg.sv
// Shared widths and dump FSM encoding for the debug-side regfile dump reader.
// Replaces the cpu_defs.vh header: REG_ADDR_W/REG_DATA_W and the DUMP_* state values.
package regfile_dump_reader_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_READ = 2'd1,
    DUMP_SEND = 2'd2,
    DUMP_DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks regfile indices FIRST_REG..LAST_REG through a spare read port and streams
// each word over valid/ready, tagged with index and last, keeping an XOR checksum.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int unsigned ADDR_W    = REG_ADDR_W,
  parameter int unsigned DATA_W    = REG_DATA_W,
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

  dump_state_e       state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              valid_nxt;
  logic [ADDR_W-1:0] index_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              last_nxt;
  logic [DATA_W-1:0] csum_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= DUMP_IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      checksum  <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      out_valid <= valid_nxt;
      out_index <= index_nxt;
      out_data  <= data_nxt;
      out_last  <= last_nxt;
      checksum  <= csum_nxt;
    end
  end

  // raddr, busy and done decode straight from state so reset clears them without an edge.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    valid_nxt = out_valid;
    index_nxt = out_index;
    data_nxt  = out_data;
    last_nxt  = out_last;
    csum_nxt  = checksum;
    raddr     = '0;
    busy      = 1'b1;
    done      = 1'b0;

    unique case (state)
      DUMP_IDLE: begin
        busy = 1'b0;
        if (start) begin
          idx_nxt   = FIRST_IDX;
          csum_nxt  = '0;
          state_nxt = DUMP_READ;
        end
      end

      DUMP_READ: begin
        raddr = idx;
        if (abort) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          state_nxt = DUMP_IDLE;
        end else begin
          data_nxt  = rdata;
          index_nxt = idx;
          last_nxt  = (idx == LAST_IDX);
          valid_nxt = 1'b1;
          state_nxt = DUMP_SEND;
        end
      end

      DUMP_SEND: begin
        // abort outranks a coincident handshake: the pending word is dropped uncounted
        if (abort) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          state_nxt = DUMP_IDLE;
        end else if (out_ready) begin
          csum_nxt  = checksum ^ out_data;
          valid_nxt = 1'b0;
          if (idx == LAST_IDX) begin
            state_nxt = DUMP_DONE;
          end else begin
            idx_nxt   = idx + ADDR_W'(1);
            state_nxt = DUMP_READ;
          end
        end
      end

      DUMP_DONE: begin
        done      = 1'b1;
        last_nxt  = 1'b0;
        state_nxt = DUMP_IDLE;
      end

      default: state_nxt = DUMP_IDLE;
    endcase
  end

endmodule
